// File: rtl/compound_accumulator_types.sv
// Types local to compound_accumulator: the report record, the two-state
// handshake FSM encoding and the saturating event-counter helper.
package compound_accumulator_types;

  localparam int ACC_W = 32;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic signed [ACC_W-1:0] sum;
    logic [CNT_W-1:0]        count;
    logic                    ovf;
  } ResultType;

  typedef enum logic {
    ST_GET = 1'b0,
    ST_PUT = 1'b1
  } state_t;

  // Increment that sticks at the top value instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/testbasic11_types.sv
// Shared testbasic11 message types.
// Holds the request mode enum and the upstream request message (CompoundType)
// that several testbasic11 blocks exchange.
package testbasic11_types;

  typedef enum logic {
    MODE_READ  = 1'b0,
    MODE_WRITE = 1'b1
  } ModeType;

  typedef struct packed {
    ModeType            mode;
    logic signed [31:0] x;
    logic               y;
  } CompoundType;

endpackage

// File: rtl/acc_add.sv
// Overflow-aware 32-bit signed adder for compound_accumulator.
// Build option COMPOUND_ACC_SATURATE_EN: when defined, an overflowing sum is
// clamped to the most positive / most negative value; otherwise it wraps.
// ovf flags signed overflow in both builds.
module acc_add
  import compound_accumulator_types::*;
(
  input  logic signed [ACC_W-1:0] a,
  input  logic signed [ACC_W-1:0] b,
  output logic signed [ACC_W-1:0] sum,
  output logic                    ovf
);

  logic signed [ACC_W-1:0] raw;

  // Two's-complement add; overflow when both operands agree in sign but the
  // result does not.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path
    // (here: assigned up front) so no latch is inferred.
    raw = a + b;
    ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
    sum = raw;
`ifdef COMPOUND_ACC_SATURATE_EN
    if (ovf) begin
      sum = a[ACC_W-1] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    end
`endif
  end

endmodule

// File: rtl/compound_accumulator.sv
// compound_accumulator: accepts write/read messages over a valid/ready
// style handshake (b_in_sync / b_in_notify), accumulates x into a signed
// accumulator with a saturating message counter and sticky overflow flag,
// and returns a registered report over a second handshake
// (res_out_notify / res_out_sync).
// Build option COMPOUND_ACC_SATURATE_EN selects clamping instead of wrapping
// on accumulator overflow (applied inside acc_add).
module compound_accumulator
  import testbasic11_types::*;
  import compound_accumulator_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  CompoundType b_in,
  input  logic        b_in_sync,
  output logic        b_in_notify,
  output ResultType   res_out,
  input  logic        res_out_sync,
  output logic        res_out_notify
);

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  ResultType               res_q, res_d;

  logic signed [ACC_W-1:0] add_sum;
  logic                    add_ovf;

  acc_add u_acc_add (
    .a   (acc_q),
    .b   (b_in.x),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // Next-state and datapath: act only on a handshake in the current state.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    res_d   = res_q;
    unique case (state_q)
      ST_GET: begin
        if (b_in_sync) begin
          if (b_in.mode == MODE_WRITE) begin
            cnt_d = sat_inc(cnt_q);
            if (b_in.y) begin
              acc_d = b_in.x;
            end else begin
              acc_d = add_sum;
              ovf_d = ovf_q | add_ovf;
            end
          end else begin
            // Report captures pre-clear values; the optional clear lands on
            // the same edge.
            res_d   = '{sum: acc_q, count: cnt_q, ovf: ovf_q};
            state_d = ST_PUT;
            if (b_in.y) begin
              acc_d = '0;
              cnt_d = '0;
              ovf_d = 1'b0;
            end
          end
        end
      end
      ST_PUT: begin
        if (res_out_sync) begin
          state_d = ST_GET;
        end
      end
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (rst) begin
      state_q <= ST_GET;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
    end
  end

  assign b_in_notify    = (state_q == ST_GET);
  assign res_out_notify = (state_q == ST_PUT);
  assign res_out        = res_q;

endmodule

// File: tb/tb_compound_accumulator.sv
// Testbench for compound_accumulator: directed scenarios followed by random
// traffic. A driver issues messages and updates an arithmetic reference
// model that queues expected reports; a monitor/consumer process pops and
// compares whenever the DUT hands over a report.
module tb_compound_accumulator;
  import testbasic11_types::*;
  import compound_accumulator_types::*;

  localparam longint IMAX = 64'sd2147483647;
  localparam longint IMIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst;
  CompoundType b_in;
  logic        b_in_sync;
  logic        b_in_notify;
  ResultType   res_out;
  logic        res_out_sync = 1'b0;
  logic        res_out_notify;

  compound_accumulator dut (
    .clk            (clk),
    .rst            (rst),
    .b_in           (b_in),
    .b_in_sync      (b_in_sync),
    .b_in_notify    (b_in_notify),
    .res_out        (res_out),
    .res_out_sync   (res_out_sync),
    .res_out_notify (res_out_notify)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state and scoreboard.
  int        m_acc;
  int        m_cnt;
  bit        m_ovf;
  ResultType exp_q[$];

  int cycle = 0;
  int read_cycle = 0;
  int stall_req = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic model_reset();
    m_acc = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_apply(input ModeType mode, input logic [31:0] x, input bit y);
    int     xi;
    longint s;
    xi = x;
    if (mode == MODE_WRITE) begin
      if (y) begin
        m_acc = xi;
      end else begin
        s = longint'(m_acc) + longint'(xi);
        if (s > IMAX || s < IMIN) begin
          m_ovf = 1'b1;
`ifdef COMPOUND_ACC_SATURATE_EN
          m_acc = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`else
          m_acc = int'(s);
`endif
        end else begin
          m_acc = int'(s);
        end
      end
      if (m_cnt < 255) m_cnt++;
    end else begin
      exp_q.push_back(ResultType'{sum: m_acc, count: 8'(m_cnt), ovf: m_ovf});
      if (y) model_reset();
    end
  endtask

  // Issue one message; waits (bounded) for the DUT to be ready.
  task automatic send(input ModeType mode, input logic [31:0] x, input bit y, input int stall = 0);
    bit got;
    got = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 500; i++) begin
      if (b_in_notify === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      check("b_in_notify_timeout", 64'd0, 64'd1);
      return;
    end
    b_in      = '{mode: mode, x: x, y: y};
    b_in_sync = 1'b1;
    if (mode == MODE_READ) stall_req = stall;
    model_apply(mode, x, y);
    @(posedge clk);
    #1;
    b_in_sync = 1'b0;
    if (mode == MODE_READ) read_cycle = cycle;
  endtask

  // Monitor and consumer: checks reports, hold stability and retention.
  bit        holding = 1'b0;
  int        stall_left = 0;
  ResultType held;
  ResultType last_rep = '0;
  ResultType e;

  always @(negedge clk) begin
    if (rst) begin
      holding      = 1'b0;
      res_out_sync = 1'b0;
      last_rep     = '0;
      exp_q.delete();
    end else if (res_out_notify) begin
      if (!holding) begin
        holding    = 1'b1;
        held       = res_out;
        stall_left = stall_req;
        check("report_latency_edges", 64'(cycle + 1 - read_cycle), 64'd1);
      end else begin
        check("report_held_stable", res_out, held);
      end
      check("b_in_notify_in_put", b_in_notify, 1'b0);
      if (stall_left > 0) begin
        stall_left--;
        res_out_sync = 1'b0;
      end else begin
        res_out_sync = 1'b1;
        holding      = 1'b0;
        last_rep     = res_out;
        if (exp_q.size() == 0) begin
          check("unexpected_report", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("report", res_out, e);
        end
      end
    end else begin
      res_out_sync = 1'b0;
      check("res_out_retained", res_out, last_rep);
    end
  end

  initial begin
    int          start;
    ModeType     md;
    logic [31:0] xv;
    logic [31:0] edge_vals [4];
    edge_vals[0] = 32'h7FFF_FFFF;
    edge_vals[1] = 32'h8000_0000;
    edge_vals[2] = 32'hFFFF_FFFF;
    edge_vals[3] = 32'h0000_0001;

    rst       = 1'b1;
    b_in      = '0;
    b_in_sync = 1'b0;
    model_reset();

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check("rst_b_in_notify", b_in_notify, 1'b1);
    check("rst_res_out_notify", res_out_notify, 1'b0);
    check("rst_res_out", res_out, 41'd0);
    #1 rst = 1'b0;

    // Two accumulating writes then a plain read: {12,2,0}.
    send(MODE_WRITE, 32'd5, 1'b0);
    send(MODE_WRITE, 32'd7, 1'b0);
    send(MODE_READ, 32'd0, 1'b0);

    // Load, read-and-clear with a stalled consumer and ignored input pulse.
    send(MODE_WRITE, 32'd100, 1'b1);
    send(MODE_READ, 32'd0, 1'b1, 3);
    @(negedge clk);
    b_in      = '{mode: MODE_WRITE, x: 32'd999, y: 1'b0};
    b_in_sync = 1'b1;
    @(posedge clk);
    #1 b_in_sync = 1'b0;
    send(MODE_READ, 32'd0, 1'b0);

    // Positive overflow: clamp or wrap depending on build, ovf set.
    send(MODE_WRITE, 32'h7FFF_FFFF, 1'b1);
    send(MODE_WRITE, 32'd1, 1'b0);
    send(MODE_READ, 32'd0, 1'b1);

    // 260 back-to-back writes: count saturates at 255, no bubbles.
    send(MODE_WRITE, 32'd1, 1'b0);
    start = cycle;
    repeat (259) send(MODE_WRITE, 32'd1, 1'b0);
    check("back_to_back_edges", 64'(cycle - start), 64'd259);
    send(MODE_READ, 32'd0, 1'b1);

    // Reset while a report is pending.
    send(MODE_WRITE, 32'd42, 1'b0);
    send(MODE_READ, 32'd0, 1'b0, 1000);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    @(negedge clk);
    #1;
    check("midput_rst_res_out_notify", res_out_notify, 1'b0);
    check("midput_rst_b_in_notify", b_in_notify, 1'b1);
    check("midput_rst_res_out", res_out, 41'd0);
    #1 rst = 1'b0;
    send(MODE_READ, 32'd0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      md = ($urandom_range(0, 4) == 0) ? MODE_READ : MODE_WRITE;
      xv = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
      send(md, xv, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end
    send(MODE_READ, 32'd0, 1'b0);

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
